// File: rtl/adsr_nco.sv
// Envelope ramp NCO: a free-running phase accumulator stepped once per sample tick, with a
// log-style step code. Define ADSR_NCO_REG_OUT_EN to add one extra output register stage.
module adsr_nco #(
  parameter int unsigned ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_rate,
  input  logic [6:0] env_time,
  output logic [6:0] env_scale,
  output logic       env_ovflow,
  output logic       env_dv
);

  localparam int unsigned ShBase = ACC_W - 9;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic [3:0]       expo;
  logic [3:0]       mant;
  logic [31:0]      shamt;

  logic [6:0] scale_q;
  logic       ovf_q;
  logic       dv_q;

  // Exponent picks the octave, mantissa walks 15..8 within it, so the step falls as the code rises.
  always_comb begin
    expo  = env_time[6:3];
    mant  = 4'd15 - {1'b0, env_time[2:0]};
    shamt = ShBase - 32'(expo);
    inc   = {{(ACC_W-4){1'b0}}, mant} << shamt;
    sum   = {1'b0, acc_q} + {1'b0, inc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      scale_q <= '0;
      ovf_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else if (sample_rate) begin
      // Wrap keeps the residue so the ramp stays phase-continuous.
      acc_q   <= sum[ACC_W-1:0];
      scale_q <= sum[ACC_W-1 -: 7];
      ovf_q   <= sum[ACC_W];
      dv_q    <= 1'b1;
    end else begin
      ovf_q   <= 1'b0;
      dv_q    <= 1'b0;
    end
  end

`ifdef ADSR_NCO_REG_OUT_EN
  logic [6:0] scale_r;
  logic       ovf_r;
  logic       dv_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scale_r <= '0;
      ovf_r   <= 1'b0;
      dv_r    <= 1'b0;
    end else begin
      scale_r <= scale_q;
      ovf_r   <= ovf_q;
      dv_r    <= dv_q;
    end
  end

  assign env_scale  = scale_r;
  assign env_ovflow = ovf_r;
  assign env_dv     = dv_r;
`else
  assign env_scale  = scale_q;
  assign env_ovflow = ovf_q;
  assign env_dv     = dv_q;
`endif

endmodule

// File: tb/tb_adsr_nco.sv
// Directed bench for adsr_nco: a vector table of tick runs plus hand sequences for hold,
// back-to-back ticks, async reset, single-step timing and the auto-advancing sweep.
module tb_adsr_nco;

`ifdef ADSR_NCO_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       sample_rate;
  logic [6:0] env_time;
  logic [6:0] env_scale;
  logic       env_ovflow;
  logic       env_dv;

  int n_vec = 0;
  int n_err = 0;

  adsr_nco #(.ACC_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_rate(sample_rate),
    .env_time   (env_time),
    .env_scale  (env_scale),
    .env_ovflow (env_ovflow),
    .env_dv     (env_dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [6:0] et;
    int         n;
    logic [6:0] scale;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  // n back-to-back ticks; returns at the negedge right after the last tick edge
  task automatic run_ticks(input int n);
    if (n > 0) begin
      @(negedge clk) sample_rate = 1'b1;
      repeat (n) @(negedge clk);
      sample_rate = 1'b0;
    end
  endtask

  initial begin
    int   bad;
    int   k;
    int   exp_sc;
    int   cnt;
    int   nsw;
    int   stray;
    int   lens[4];
    int   b2b[3];

    vecs[0] = '{1'b1, 7'd0,  1,  7'd3,   1'b0};
    vecs[1] = '{1'b0, 7'd0,  33, 7'd127, 1'b0};
    vecs[2] = '{1'b0, 7'd0,  1,  7'd3,   1'b1};
    vecs[3] = '{1'b1, 7'd8,  68, 7'd127, 1'b0};
    vecs[4] = '{1'b0, 7'd8,  1,  7'd1,   1'b1};
    vecs[5] = '{1'b1, 7'd0,  2,  7'd7,   1'b0};
    vecs[6] = '{1'b0, 7'd8,  1,  7'd9,   1'b0};
    vecs[7] = '{1'b0, 7'd3,  1,  7'd12,  1'b0};
    vecs[8] = '{1'b0, 7'd17, 1,  7'd13,  1'b0};
    vecs[9] = '{1'b0, 7'd2,  1,  7'd16,  1'b0};
    b2b[0] = 3; b2b[1] = 7; b2b[2] = 11;

    rst = 1'b0;
    sample_rate = 1'b1;
    env_time = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset_scale", int'(env_scale), 0);
    chk("reset_ovf", int'(env_ovflow), 0);
    chk("reset_dv", int'(env_dv), 0);
    sample_rate = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) rst_pulse();
      @(negedge clk) env_time = vecs[i].et;
      run_ticks(vecs[i].n - 1);
      run_ticks(1);
      repeat (LAT - 1) @(negedge clk);
      chk($sformatf("vec%0d_scale", i), int'(env_scale), int'(vecs[i].scale));
      chk($sformatf("vec%0d_ovf", i), int'(env_ovflow), int'(vecs[i].ovf));
      chk($sformatf("vec%0d_dv", i), int'(env_dv), 1);
    end

    // Long idle must leave the accumulator untouched.
    rst_pulse();
    env_time = 7'd0;
    run_ticks(5);
    repeat (LAT) @(negedge clk);
    chk("hold_start_scale", int'(env_scale), 18);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (env_dv || env_ovflow || env_scale != 7'd18) bad++;
    end
    chk("hold_quiet", bad, 0);
    run_ticks(1);
    repeat (LAT - 1) @(negedge clk);
    chk("hold_resume_scale", int'(env_scale), 22);
    chk("hold_resume_ovf", int'(env_ovflow), 0);

    // Three consecutive ticks: three updates, dv high three cycles.
    rst_pulse();
    @(negedge clk) sample_rate = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      k = j - LAT + 1;
      exp_sc = (k < 1) ? 0 : (k > 3) ? 11 : b2b[k-1];
      chk($sformatf("b2b%0d_dv", j), int'(env_dv), (k >= 1 && k <= 3) ? 1 : 0);
      chk($sformatf("b2b%0d_scale", j), int'(env_scale), exp_sc);
      if (j == 3) sample_rate = 1'b0;
    end

    // Asynchronous reset between edges, then first tick restarts from zero.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_scale", int'(env_scale), 0);
    chk("arst_ovf", int'(env_ovflow), 0);
    chk("arst_dv", int'(env_dv), 0);
    @(negedge clk) rst = 1'b1;
    run_ticks(1);
    repeat (LAT - 1) @(negedge clk);
    chk("arst_first_tick", int'(env_scale), 3);

    // Slowest code: first step of env_scale lands exactly on tick 16384.
    rst_pulse();
    env_time = 7'd127;
    run_ticks(16383);
    repeat (LAT) @(negedge clk);
    chk("slow_pre_scale", int'(env_scale), 0);
    run_ticks(1);
    for (int j = 1; j <= 3; j++) begin
      if (j > 1) @(negedge clk);
      chk($sformatf("slow%0d_dv", j), int'(env_dv), (j == LAT) ? 1 : 0);
      chk($sformatf("slow%0d_scale", j), int'(env_scale), (j >= LAT) ? 1 : 0);
    end

    // Caller advances env_time on each overflow strobe; ticks every 4 clocks.
    rst_pulse();
    env_time = 7'd0;
    cnt = 0;
    nsw = 0;
    stray = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (env_ovflow && !env_dv) stray++;
      if (env_dv) begin
        cnt++;
        if (env_ovflow) begin
          if (nsw < 4) lens[nsw] = cnt;
          nsw++;
          cnt = 0;
          env_time = env_time + 7'd1;
        end
      end
      if (nsw >= 4) break;
      sample_rate = (c % 4 == 0);
    end
    sample_rate = 1'b0;
    chk("sweep_count", nsw, 4);
    chk("sweep_stray_ovf", stray, 0);
    chk("sweep_env_time", int'(env_time), 4);
    if (nsw >= 4) begin
      chk("sweep0_len", lens[0], 35);
      chk("sweep1_len", lens[1], 36);
      chk("sweep2_len", lens[2], 39);
      chk("sweep3_len", lens[3], 43);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adsr_nco.md
ADSR_NCO -- requirements
Module: adsr_nco

Interface
REQ-001 Parameter ACC_W, default 24, phase-accumulator width in bits; legal range ACC_W >= 24.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 sample_rate  input  1  one-clk-wide tick at the audio sample rate, nominally 32 kHz, i.e. 100 MHz/3125 from prescaler MODULO=3125, W=12.
REQ-005 env_time  input  7  envelope segment duration code; 0 is the shortest, 127 the longest.
REQ-006 env_scale  output  7  envelope ramp position, 0..127.
REQ-007 env_ovflow  output  1  ramp wrapped on the current update; valid only while env_dv=1.
REQ-008 env_dv  output  1  one-cycle strobe marking fresh env_scale/env_ovflow.

Function
REQ-009 The block SHALL hold an unsigned ACC_W-bit phase accumulator acc.
REQ-010 With e=env_time[6:3] and m=env_time[2:0], the increment SHALL be inc = (15-m) << (ACC_W-9-e). This is a monotonically decreasing step as env_time rises.
REQ-011 On a clk edge with sample_rate=1, the block SHALL:
- set acc <= (acc+inc) mod 2^ACC_W;
- set env_ovflow <= carry-out of that addition;
- set env_dv <= 1.
REQ-012 On a clk edge with sample_rate=0:
- acc SHALL hold;
- env_dv SHALL be 0;
- env_ovflow SHALL be 0.
REQ-013 env_scale SHALL equal acc[ACC_W-1:ACC_W-7], registered.
- It changes only in the cycle in which env_dv is asserted.
- Latency is 1 clk from the sample_rate tick to env_dv/env_scale.
REQ-014 env_time SHALL be sampled only on tick edges. A change in env_time SHALL affect only subsequent increments and SHALL NOT clear acc.
REQ-015 On wrap, the residue SHALL be kept (acc = sum - 2^ACC_W). This gives phase-continuous free-running; there is no saturation.
REQ-016 Back-to-back ticks (sample_rate high for consecutive cycles) SHALL each perform one update. env_dv then stays high for the same number of cycles.
REQ-017 A caller stepping env_time on (env_ovflow && env_dv) SHALL observe exactly one overflow strobe per full 0..127 sweep.

Reset
REQ-018 While rst=0, the block SHALL hold acc=0, env_scale=0, env_ovflow=0 and env_dv=0, regardless of clk and sample_rate.
REQ-019 Reset assertion mid-sweep SHALL clear acc immediately. After release, the first tick SHALL yield acc=inc.

Configuration
REQ-020 Macro ADSR_NCO_REG_OUT_EN.
- When defined: env_scale, env_ovflow and env_dv SHALL pass through one extra register stage, giving latency 2 clk from tick to env_dv. That stage resets to 0.
- When undefined: latency SHALL be 1 clk as in REQ-013.
- Values and cycle ordering are otherwise identical in both builds.

Verification
REQ-021 env_time=0, ACC_W=24, reset then ticks:
- tick 1 -> env_scale=3 (acc=491520), env_ovflow=0;
- tick 34 -> env_scale=127, env_ovflow=0;
- tick 35 -> env_ovflow=1, env_scale=3 (acc=425984).
REQ-022 env_time=8 (inc=245760) from reset:
- tick 68 -> env_ovflow=0, env_scale=127;
- tick 69 -> env_ovflow=1.
REQ-023 env_time=127 (inc=8): env_scale steps 0->1 exactly on tick 16384, with env_dv asserted in the cycle after that tick only.
REQ-024 Hold sample_rate=0 for 1000 clk after any state -> acc, env_scale unchanged; env_dv=0 and env_ovflow=0 throughout.
REQ-025 Pull rst low asynchronously, between clk edges, mid-sweep -> all outputs 0 before the next clk edge; with env_time=0, the first post-release tick gives env_scale=3.
REQ-026 Auto-increment env_time on (env_ovflow && env_dv) with prescaler ticks -> env_time advances 0,1,2,... with exactly one overflow strobe per sweep, and sweep length is non-decreasing. Repeat with ADSR_NCO_REG_OUT_EN defined -> identical sequence, 1 clk later.
